// File: rtl/mem_lsu_rmw.sv
// rtl/mem_lsu_rmw.sv - byte-addressed load/store initiator with read-modify-write for sub-word stores
module mem_lsu_rmw #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wbe,
    output logic [3:0]        mem_rbe,
    output logic              mem_wen,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]        state;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       old_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              misaligned;
    logic [31:0]       lane;
    logic [31:0]       load_ext;
    logic [31:0]       lane_mask;
    logic [31:0]       merged;

    // Request-side alignment check: halves need an even offset, words offset 0, size 3 is never legal.
    always_comb begin
        misaligned = 1'b0;
        if (req_size == 2'd3)
            misaligned = 1'b1;
        else if (req_size == 2'd2 && req_addr[1:0] != 2'd0)
            misaligned = 1'b1;
        else if (req_size == 2'd1 && req_addr[0])
            misaligned = 1'b1;
    end

    // Load lane extraction: shift the addressed lane down to bit 0, then sign/zero-extend by size.
    always_comb begin
        lane     = mem_rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (size_q)
            2'd0:    load_ext = uns_q ? {24'h000000, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'd1:    load_ext = uns_q ? {16'h0000, lane[15:0]}   : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Store data merge: sub-word stores overlay the shifted lane(s) onto the old word so untouched bytes survive.
    always_comb begin
        lane_mask = ((size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << {off_q, 3'b000};
        merged    = (old_q & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
    end

    // Strobes and response outputs are pure functions of state, so reset clears them at once.
    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        mem_addr  = addr_q;
        mem_rbe   = (state == S_LOAD || state == S_RMW_RD) ? 4'hF : 4'h0;
        mem_wen   = (state == S_WRITE);
        mem_wbe   = (state == S_WRITE) ? 4'hF : 4'h0;
        mem_wdata = 32'h0;
        if (state == S_WRITE)
            mem_wdata = (size_q == 2'd2) ? wdata_q : merged;
    end

    // Main sequencer: accept, optionally read old word / load, write, then hold the response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            old_q   <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        off_q   <= req_addr[1:0];
                        addr_q  <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        rdata_q <= 32'h0;
                        err_q   <= misaligned;
                        if (misaligned)
                            state <= S_RESP;
                        else if (!req_we)
                            state <= S_LOAD;
                        else if (req_size == 2'd2)
                            state <= S_WRITE;
                        else
                            state <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    rdata_q <= load_ext;
                    state   <= S_RESP;
                end
                S_RMW_RD: begin
                    old_q <= mem_rdata;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The latched store kind is implied by the state path; keep it for debug visibility only.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_mem_lsu_rmw.sv
// tb/tb_mem_lsu_rmw.sv - self-checking bench for mem_lsu_rmw against a byte-level memory model
module tb_mem_lsu_rmw;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wbe;
    logic [3:0]    mem_rbe;
    logic          mem_wen;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int rbe_cnt = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_wbe = 4'h0;
    logic        ram_clear;

    logic [31:0] ram [0:1023];
    logic [7:0]  ref_bytes [0:4095];

    always #5 clk = ~clk;

    mem_lsu_rmw #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wbe(mem_wbe), .mem_rbe(mem_rbe),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    // RAM: masked combinational read, masked word write (unenabled bytes become zero).
    assign mem_rdata = ram[mem_addr[9:0]] & be_mask(mem_rbe);

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        end else if (mem_wen) begin
            ram[mem_addr[9:0]] <= mem_wdata & be_mask(mem_wbe);
        end
    end

    always @(negedge clk) begin
        if (mem_wen) begin
            wen_cnt    = wen_cnt + 1;
            last_wdata = mem_wdata;
            last_wbe   = mem_wbe;
        end
        if (mem_rbe != 4'h0) rbe_cnt = rbe_cnt + 1;
    end

    // Reference model: memory as individual bytes, little-endian.
    function automatic logic model_err(input logic [1:0] size, input logic [25:0] addr);
        int n;
        if (size == 2'd3) return 1'b1;
        n = 1 << size;
        return (int'(addr[11:0]) % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns, input logic [25:0] addr);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(addr[11:0]) + i]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic int model_lat(input logic we, input logic [1:0] size, input logic er);
        if (er) return 1;
        if (!we) return 2;
        if (size == 2'd2) return 2;
        return 3;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [25:0] addr, input logic [31:0] wd);
        for (int i = 0; i < (1 << size); i++) ref_bytes[int'(addr[11:0]) + i] = wd[8*i +: 8];
    endtask

    // Issue one request and complete its response; call at #1 after a rising edge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [25:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int guard;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout addr=%h got no rsp_valid, required rsp_valid within 20 cycles", addr);
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!model_err(size, addr) && we) model_store(size, addr, wd);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b required 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b required 0", rsp_valid); end
        checks++; if ({mem_wen, mem_wbe, mem_rbe} !== 9'h0) begin errors++; $display("FAIL reset_strobes got %h required 0", {mem_wen, mem_wbe, mem_rbe}); end
        checks++; if ({rsp_rdata, rsp_err} !== 33'h0) begin errors++; $display("FAIL reset_rsp got %h required 0", {rsp_rdata, rsp_err}); end
        checks++; if ({mem_addr, mem_wdata} !== 56'h0) begin errors++; $display("FAIL reset_mem_bus got %h required 0", {mem_addr, mem_wdata}); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; ram_clear = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b required 1", req_ready); end
    endtask

    task automatic test_word_store_load;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'd2, 1'b0, 26'h10, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d required 2", lat); end
        checks++; if ({er, rd} !== 33'h0) begin errors++; $display("FAIL sw_rsp got %h required 0", {er, rd}); end
        do_req(1'b0, 2'd2, 1'b0, 26'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h required deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got %b required 0", er); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d required 2", lat); end
    endtask

    task automatic test_byte_rmw;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'd2, 1'b0, 26'h20, 32'h11223344, rd, er, lat);
        do_req(1'b1, 2'd0, 1'b0, 26'h22, 32'h000000AA, rd, er, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_latency got %0d required 3", lat); end
        checks++; if (last_wdata !== 32'h11AA3344) begin errors++; $display("FAIL sb_wdata got %h required 11aa3344", last_wdata); end
        checks++; if (last_wbe !== 4'hF) begin errors++; $display("FAIL sb_wbe got %h required f", last_wbe); end
        do_req(1'b0, 2'd2, 1'b0, 26'h20, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL sb_reload got %h required 11aa3344", rd); end
    endtask

    task automatic test_extension;
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 2'd2, 1'b0, 26'h30, 32'h80FF7F01, rd, er, lat);
        do_req(1'b0, 2'd0, 1'b0, 26'h32, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb got %h required ffffffff", rd); end
        do_req(1'b0, 2'd0, 1'b1, 26'h32, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h000000FF) begin errors++; $display("FAIL lbu got %h required 000000ff", rd); end
        do_req(1'b0, 2'd1, 1'b0, 26'h32, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh got %h required ffff80ff", rd); end
        do_req(1'b0, 2'd1, 1'b1, 26'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00007F01) begin errors++; $display("FAIL lhu got %h required 00007f01", rd); end
    endtask

    task automatic test_misaligned;
        logic [31:0] rd; logic er; int lat; int w0; int r0;
        logic        t_we   [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  t_size [3] = '{2'd2, 2'd1, 2'd3};
        logic [25:0] t_addr [3] = '{26'h41, 26'h43, 26'h40};
        do_req(1'b1, 2'd2, 1'b0, 26'h40, 32'hCAFEF00D, rd, er, lat);
        w0 = wen_cnt; r0 = rbe_cnt;
        for (int i = 0; i < 3; i++) begin
            do_req(t_we[i], t_size[i], 1'b0, t_addr[i], 32'h00001234, rd, er, lat);
            checks++; if ({er, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL misaligned_rsp[%0d] got err=%b data=%h required err=1 data=0", i, er, rd); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL misaligned_latency[%0d] got %0d required 1", i, lat); end
        end
        checks++; if (wen_cnt !== w0 || rbe_cnt !== r0) begin errors++; $display("FAIL misaligned_strobes got wen=%0d rbe=%0d required wen=%0d rbe=%0d", wen_cnt, rbe_cnt, w0, r0); end
        do_req(1'b0, 2'd2, 1'b0, 26'h40, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL misaligned_mem got %h required cafef00d", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_rd;
        exp_rd = model_load(2'd2, 1'b0, 26'h10);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 26'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_addr = 26'h30;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd) begin errors++; $display("FAIL stall_rsp[%0d] got valid=%b data=%h required valid=1 data=%h", c, rsp_valid, rsp_rdata, exp_rd); end
            checks++; if (req_ready !== 1'b0 || mem_addr !== 24'h4) begin errors++; $display("FAIL stall_no_accept[%0d] got ready=%b addr=%h required ready=0 addr=4", c, req_ready, mem_addr); end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got ready=%b valid=%b required ready=1 valid=0", req_ready, rsp_valid); end
    endtask

    task automatic test_reset_mid_rmw;
        logic [31:0] rd; logic er; int lat; int w0; logic [31:0] exp_word;
        exp_word = model_load(2'd2, 1'b0, 26'h20);
        w0 = wen_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 26'h21; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (mem_rbe !== 4'hF) begin errors++; $display("FAIL rmw_rd_rbe got %h required f", mem_rbe); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({mem_wen, mem_rbe, mem_wbe, rsp_valid} !== 10'h0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_outputs got wen=%b rbe=%h wbe=%h valid=%b ready=%b", mem_wen, mem_rbe, mem_wbe, rsp_valid, req_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (wen_cnt !== w0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_wen got wen=%0d ready=%b required wen=%0d ready=1", wen_cnt, req_ready, w0); end
        do_req(1'b0, 2'd2, 1'b0, 26'h20, 32'h0, rd, er, lat);
        checks++; if (rd !== exp_word) begin errors++; $display("FAIL reset_mid_mem got %h required %h", rd, exp_word); end
    endtask

    task automatic test_random;
        logic [31:0] rd; logic er; int lat;
        logic we; logic [1:0] size; logic uns; logic [25:0] addr; logic [31:0] wd;
        logic e_er; logic [31:0] e_rd; int e_lat;
        for (int k = 0; k < 300; k++) begin
            we   = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 26'($urandom_range(0, 255));
            wd   = $urandom;
            e_er  = model_err(size, addr);
            e_rd  = (!we && !e_er) ? model_load(size, uns, addr) : 32'h0;
            e_lat = model_lat(we, size, e_er);
            do_req(we, size, uns, addr, wd, rd, er, lat);
            checks++; if ({er, rd} !== {e_er, e_rd}) begin errors++; $display("FAIL rand_rsp[%0d] we=%b size=%0d addr=%h got err=%b data=%h required err=%b data=%h", k, we, size, addr, er, rd, e_er, e_rd); end
            checks++; if (lat !== e_lat) begin errors++; $display("FAIL rand_latency[%0d] got %0d required %0d", k, lat, e_lat); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;
        rst = 1'b1; ram_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'h0; rsp_ready = 1'b0;
        test_reset;
        test_word_store_load;
        test_byte_rmw;
        test_extension;
        test_misaligned;
        test_backpressure;
        test_reset_mid_rmw;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
